// File: rtl/fetch_sequencer_if.sv
// Sequencer <-> datapath/ROM signal bundle; master is the sequencer side.
interface fetch_sequencer_if;
  logic        start_i;
  logic [1:0]  prog_sel_i;
  logic        stall_i;
  logic [7:0]  instr_i;
  logic        flag_i;
  logic [7:0]  br_offset_i;
  logic [7:0]  rom_addr_o;
  logic [7:0]  instr_o;
  logic        instr_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        fault_o;
  logic [15:0] icount_o;

  modport master (
    input  start_i, prog_sel_i, stall_i, instr_i, flag_i, br_offset_i,
    output rom_addr_o, instr_o, instr_valid_o, busy_o, done_o, fault_o, icount_o
  );

  modport slave (
    output start_i, prog_sel_i, stall_i, instr_i, flag_i, br_offset_i,
    input  rom_addr_o, instr_o, instr_valid_o, busy_o, done_o, fault_o, icount_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns pc, fetches from a combinational ROM with zero latency,
// resolves branch/branchb/halt, one commit per cycle unless stalled.
module fetch_sequencer #(
  parameter logic [7:0] PROG0_BASE = 8'd0,
  parameter logic [7:0] PROG1_BASE = 8'd100,
  parameter logic [7:0] PROG2_BASE = 8'd152
) (
  input  logic              clk_i,
  input  logic              reset_i,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_FAULT} state_t;

  localparam logic [7:0] OP_HALT = 8'h88;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] icount_q, icount_d;
  logic [7:0]  base_sel;
  logic        is_branch, is_branchb;

  always_comb begin
    case (bus.prog_sel_i)
      2'd1:    base_sel = PROG1_BASE;
      2'd2:    base_sel = PROG2_BASE;
      default: base_sel = PROG0_BASE;
    endcase
  end

  assign is_branch  = (bus.instr_i[7:3] == 5'b11110);
  assign is_branchb = (bus.instr_i[7:3] == 5'b10110);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    case (state_q)
      S_RUN: begin
        if (!bus.stall_i) begin
          if (bus.instr_i == OP_HALT) begin
            state_d = S_HALTED;
          end else begin
            if (icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
            // Branch targets wrap freely; only a sequential step past 255 faults.
            if (is_branch && bus.flag_i) begin
              pc_d = pc_q + 8'd1 + bus.br_offset_i;
            end else if (is_branchb && bus.flag_i) begin
              pc_d = pc_q + 8'd1 - bus.br_offset_i;
            end else if (pc_q == 8'hFF) begin
              state_d = S_FAULT;
            end else begin
              pc_d = pc_q + 8'd1;
            end
          end
        end
      end
      default: begin
        if (bus.start_i) begin
          state_d  = S_RUN;
          pc_d     = base_sel;
          icount_d = 16'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      pc_q     <= 8'd0;
      icount_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
    end
  end

  assign bus.rom_addr_o    = pc_q;
  assign bus.busy_o        = (state_q == S_RUN);
  assign bus.done_o        = (state_q == S_HALTED);
  assign bus.fault_o       = (state_q == S_FAULT);
  assign bus.icount_o      = icount_q;
  assign bus.instr_o       = bus.busy_o ? bus.instr_i : 8'h00;
  assign bus.instr_valid_o = bus.busy_o && (bus.instr_i != OP_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a reference model predicts each cycle's outputs.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [7:0]  rom_addr;
    logic [7:0]  instr;
    logic        valid;
    logic        busy;
    logic        done;
    logic        fault;
    logic [15:0] icount;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] rom [256];
  exp_t exp_q [$];
  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 run, 2 halted, 3 fault
  int          m_state;
  logic [7:0]  m_pc;
  logic [15:0] m_icnt;

  fetch_sequencer_if bus ();
  assign bus.instr_i = rom[bus.rom_addr_o];

  fetch_sequencer dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.rom_addr = m_pc;
    e.busy     = (m_state == 1);
    e.done     = (m_state == 2);
    e.fault    = (m_state == 3);
    e.icount   = m_icnt;
    e.instr    = (m_state == 1) ? rom[m_pc] : 8'h00;
    e.valid    = (m_state == 1) && (rom[m_pc] != 8'h88);
    return e;
  endfunction

  task automatic model_advance();
    logic [7:0] ins;
    ins = rom[m_pc];
    if (m_state != 1) begin
      if (bus.start_i) begin
        m_state = 1;
        m_icnt  = 16'd0;
        m_pc    = (bus.prog_sel_i == 2'd1) ? 8'd100 : (bus.prog_sel_i == 2'd2) ? 8'd152 : 8'd0;
      end
    end else if (!bus.stall_i) begin
      if (ins == 8'h88) begin
        m_state = 2;
      end else begin
        if (m_icnt != 16'hFFFF) m_icnt = m_icnt + 16'd1;
        if (ins[7:3] == 5'b11110 && bus.flag_i)      m_pc = m_pc + 8'd1 + bus.br_offset_i;
        else if (ins[7:3] == 5'b10110 && bus.flag_i) m_pc = m_pc + 8'd1 - bus.br_offset_i;
        else if (m_pc == 8'hFF)                      m_state = 3;
        else                                         m_pc = m_pc + 8'd1;
      end
    end
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    model_advance();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rom_addr", {24'd0, bus.rom_addr_o}, {24'd0, e.rom_addr});
    check("instr_o", {24'd0, bus.instr_o}, {24'd0, e.instr});
    check("instr_valid", {31'd0, bus.instr_valid_o}, {31'd0, e.valid});
    check("busy", {31'd0, bus.busy_o}, {31'd0, e.busy});
    check("done", {31'd0, bus.done_o}, {31'd0, e.done});
    check("fault", {31'd0, bus.fault_o}, {31'd0, e.fault});
    check("icount", {16'd0, bus.icount_o}, {16'd0, e.icount});
  endtask

  task automatic run_to(input logic [7:0] target);
    int n;
    n = 0;
    bus.flag_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.start_i = 1'b0;
    while (bus.rom_addr_o != target && n < 300) begin
      step();
      n++;
    end
    if (bus.rom_addr_o != target) check("run_to_timeout", {24'd0, bus.rom_addr_o}, {24'd0, target});
  endtask

  task automatic start_prog(input logic [1:0] sel, input logic stall);
    bus.start_i = 1'b1;
    bus.prog_sel_i = sel;
    bus.stall_i = stall;
    step();
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc = 8'd0;
    m_icnt = 16'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {24'd0, bus.rom_addr_o}, 32'd0);
    check({tag, "_instr"}, {24'd0, bus.instr_o}, 32'd0);
    check({tag, "_flags"}, {28'd0, bus.instr_valid_o, bus.busy_o, bus.done_o, bus.fault_o}, 32'd0);
    check({tag, "_icount"}, {16'd0, bus.icount_o}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h01;
    rom[17] = 8'hF7; rom[49] = 8'hB6; rom[55] = 8'h88; rom[221] = 8'h88;
    rom[102] = 8'hF7; rom[250] = 8'hF4; rom[254] = 8'hF5; rom[5] = 8'hB0;

    rst = 1'b1;
    bus.start_i = 1'b0; bus.prog_sel_i = 2'd0; bus.stall_i = 1'b0;
    bus.flag_i = 1'b0; bus.br_offset_i = 8'd0;
    model_reset();
    #3;
    check_all_zero("reset");
    #9 rst = 1'b0;
    step(); step();

    // Launch, then reset asynchronously mid-run at pc=40
    start_prog(2'd0, 1'b0);
    check("start_addr", {24'd0, bus.rom_addr_o}, 32'd0);
    check("start_busy", {31'd0, bus.busy_o}, 32'd1);
    run_to(8'd40);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    #1 rst = 1'b0;
    model_reset();
    step(); step();
    check("idle_after_reset", {31'd0, bus.busy_o}, 32'd0);

    // prog_sel=3 aliases program 0; branch taken/untaken both directions
    start_prog(2'd3, 1'b0);
    run_to(8'd17);
    bus.flag_i = 1'b1; bus.br_offset_i = 8'd8; step();
    check("fwd_taken", {24'd0, bus.rom_addr_o}, 32'd26);
    run_to(8'd49);
    bus.flag_i = 1'b1; bus.br_offset_i = 8'd38; step();
    check("back_taken", {24'd0, bus.rom_addr_o}, 32'd12);
    run_to(8'd17);
    bus.br_offset_i = 8'd8; step();
    check("fwd_untaken", {24'd0, bus.rom_addr_o}, 32'd18);
    run_to(8'd49);
    bus.br_offset_i = 8'd38; step();
    check("back_untaken", {24'd0, bus.rom_addr_o}, 32'd50);
    run_to(8'd55);
    step();
    check("halt_done", {31'd0, bus.done_o}, 32'd1);

    // Program 2: start wins over stall, stall freezes, run to halt
    start_prog(2'd2, 1'b1);
    check("p2_base", {24'd0, bus.rom_addr_o}, 32'd152);
    run_to(8'd160);
    check("pre_stall_icount", {16'd0, bus.icount_o}, 32'd8);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("stall_pc", {24'd0, bus.rom_addr_o}, 32'd160);
    check("stall_icount", {16'd0, bus.icount_o}, 32'd8);
    run_to(8'd221);
    step();
    check("p2_done", {31'd0, bus.done_o}, 32'd1);
    check("p2_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    check("p2_icount", {16'd0, bus.icount_o}, 32'd69);

    // Restart program 1 from HALTED; start ignored while busy
    start_prog(2'd1, 1'b0);
    check("p1_base", {24'd0, bus.rom_addr_o}, 32'd100);
    check("p1_icount", {16'd0, bus.icount_o}, 32'd0);
    start_prog(2'd2, 1'b0);
    check("start_in_run", {24'd0, bus.rom_addr_o}, 32'd101);

    // Reach 255 by branches, then a sequential step faults
    run_to(8'd102);
    bus.flag_i = 1'b1; bus.br_offset_i = 8'd147; step();
    check("to_250", {24'd0, bus.rom_addr_o}, 32'd250);
    bus.flag_i = 1'b1; bus.br_offset_i = 8'd4; step();
    check("to_255", {24'd0, bus.rom_addr_o}, 32'd255);
    bus.flag_i = 1'b0; step();
    check("fault", {31'd0, bus.fault_o}, 32'd1);
    check("fault_pc", {24'd0, bus.rom_addr_o}, 32'd255);
    check("fault_icount", {16'd0, bus.icount_o}, 32'd5);
    step();

    // Wrap on a taken branch is legal
    start_prog(2'd1, 1'b0);
    run_to(8'd102);
    bus.flag_i = 1'b1; bus.br_offset_i = 8'd151; step();
    check("to_254", {24'd0, bus.rom_addr_o}, 32'd254);
    bus.flag_i = 1'b1; bus.br_offset_i = 8'd5; step();
    check("wrap_addr", {24'd0, bus.rom_addr_o}, 32'd4);
    check("wrap_nofault", {31'd0, bus.fault_o}, 32'd0);
    bus.flag_i = 1'b0; step();

    // branchb by 1 at pc=5 spins in place to saturate icount
    bus.flag_i = 1'b1; bus.br_offset_i = 8'd1;
    for (int i = 0; i < 65540; i++) step();
    check("sat_icount", {16'd0, bus.icount_o}, 32'h0000FFFF);
    check("sat_pc", {24'd0, bus.rom_addr_o}, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
